int_ack_ctrl: RTL and testbench
===============================

Name: int_ack_ctrl

Overview:
Memory-mapped interrupt source controller on the CPU side of the external interrupt line of the P7 MIPS system. It samples the external `interrupt` input and holds a pending flag. It drives `irq` into CP0 as HWInt. It clears the pending flag when the CPU stores to the acknowledge address 0x7F20. It also provides an enable/mode control register and an accepted-interrupt counter, so handler code can acknowledge requests and inspect them.

Parameters:
BASE_ADDR, 32'h00007F20, word address of the ACK register; CTRL is at BASE+4, COUNT at BASE+8.
CTRL_RST, 2'b01, reset value of CTRL: bit0 = enable, bit1 = mode (0 = level, 1 = edge).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
interrupt  input  1  external interrupt request line; changes only on negedge clk.
addr  input  32  bus byte address from the M stage; bits [1:0] are ignored for decode.
wdata  input  32  store data.
byteen  input  4  byte enables; any nonzero value is a write.
rdata  output  32  combinational read data for the selected register; 0 when the address misses.
hit  output  1  combinational: word address equals BASE, BASE+4 or BASE+8.
irq  output  1  registered interrupt request to CP0 (HWInt).

Behaviour:
- Reset (sync, at posedge with reset=1):
  - state=IDLE, pending=0, irq=0.
  - CTRL=CTRL_RST, COUNT=0, the interrupt sample register (int_q) = 0.
- Sampling: int_q <= interrupt on every posedge.
  - level mode: trigger = interrupt.
  - edge mode: trigger = interrupt & ~int_q.
  - Accepted event = trigger & enable & (state==IDLE).
- Write decode: wr = |byteen & hit. A write to BASE+4 or BASE+8 uses the byte enables; non-enabled bytes are kept.
- State machine:
  - IDLE: on an accepted event -> PENDING; pending<=1; COUNT<=COUNT+1 (32-bit, wraps 0xFFFFFFFF->0).
  - PENDING: a write to BASE (any data, any nonzero byteen) clears pending.
    - level mode with interrupt still high at that edge -> ACKED.
    - otherwise -> IDLE.
  - ACKED: -> IDLE on the first posedge that samples interrupt=0. No re-trigger while the line stays high after an ack.
  - Edge mode never enters ACKED.
- irq <= pending_next & enable.
  - Latency: line sampled high at posedge N -> irq=1 after posedge N.
  - ACK store at posedge M -> irq=0 after posedge M.
- Simultaneous ACK write and new edge-mode rising edge in PENDING: ACK clears, then the new event is accepted at the same edge. Result: pending stays 1, state PENDING, COUNT+1.
- Clearing enable (CTRL bit0 <- 0):
  - irq drops after that edge.
  - pending is retained.
  - irq reasserts when enable is set again and pending is still 1.
- Writing CTRL.mode while PENDING does not change pending; the new mode governs the next trigger.
- COUNT write: loads the byte-enabled bytes of wdata. An accepted event at the same edge has priority: COUNT <= written value + 1.
- Reads:
  - BASE returns {31'b0, pending}.
  - BASE+4 returns {30'b0, CTRL}.
  - BASE+8 returns COUNT.
- Reset mid-PENDING or mid-ACKED: returns to IDLE with irq=0 at that posedge. A line still held high is re-accepted only after reset deasserts, and only in level mode.

Test Plan:
- Level ACK round trip:
  - Stimulus: reset 2 cycles; interrupt=1 at negedge (cycle 3).
  - Required: irq=1 after the next posedge; rdata@0x7F20=1; COUNT=1.
  - Stimulus: store byteen=4'hF to 0x7F20; interrupt dropped at the following negedge.
  - Required: irq=0 after that posedge; state passes through ACKED then IDLE; COUNT stays 1.
- Level hold after ACK:
  - Stimulus: interrupt held high 10 cycles across the ACK.
  - Required: irq stays 0 until the line goes low and then high again, which gives COUNT=2.
- Edge mode with simultaneous ACK and new edge:
  - Stimulus: write CTRL=3; pulse interrupt for 1 cycle; irq=1; then ACK store and a new rising edge at the same posedge.
  - Required: irq stays 1; COUNT=2.
- Enable gating:
  - Stimulus: pending=1; write CTRL=0.
  - Required: irq=0 next cycle; rdata@0x7F20 still 1.
  - Stimulus: write CTRL=1.
  - Required: irq=1 again.
- COUNT wrap and partial write:
  - Stimulus: write 0xFFFFFFFF to 0x7F28; accepted event.
  - Required: COUNT=0.
  - Stimulus: byteen=4'b0001 write of 0x000000AB.
  - Required: COUNT=0x000000AB.
- Reset mid-PENDING:
  - Stimulus: pending=1; reset pulse 1 cycle with interrupt=0.
  - Required: irq=0; CTRL=1; COUNT=0; rdata@0x7F20=0.
  - Stimulus: access to 0x7F2C.
  - Required: hit=0, rdata=0.

Source files
------------

// File: rtl/int_ack_ctrl_if.sv
// Bus bundle between the M-stage store/load path and the interrupt ack controller.
//   addr   : byte address (bits [1:0] ignored by the slave)
//   wdata  : store data
//   byteen : byte enables, nonzero means write
//   rdata  : combinational read data from the slave
//   hit    : combinational address match from the slave
interface int_ack_ctrl_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  byteen;
   logic [31:0] rdata;
   logic        hit;

   modport master (output addr, output wdata, output byteen, input rdata, input hit);
   modport slave  (input addr, input wdata, input byteen, output rdata, output hit);
endinterface

// File: rtl/int_ack_ctrl.sv
// Interrupt source controller: samples the external interrupt line, holds a
// pending flag, drives irq to CP0, and exposes ACK / CTRL / COUNT registers.
//   clk       : system clock
//   reset     : synchronous active-high reset
//   interrupt : external request line (changes on negedge clk)
//   bus       : slave side of the register bus (addr/wdata/byteen/rdata/hit)
//   irq       : registered interrupt request to CP0 (HWInt)
module int_ack_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h00007F20,
   parameter logic [1:0]  CTRL_RST  = 2'b01
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           interrupt,
   int_ack_ctrl_if.slave  bus,
   output logic           irq
);

   localparam int unsigned DW = 32;
   localparam logic [29:0] ACK_W  = BASE_ADDR[31:2];
   localparam logic [29:0] CTRL_W = ACK_W + 30'd1;
   localparam logic [29:0] CNT_W  = ACK_W + 30'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ACKED   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      ctrl, ctrl_nxt;
   logic [DW-1:0]   count, count_nxt, count_base;
   logic            int_q;
   logic            irq_nxt;

   logic            sel_ack, sel_ctrl, sel_cnt;
   logic            wr, trigger, accept;
   logic            enable, mode;
   logic            pending;
   logic            unused_addr_lo;

   // Byte-enable merge of a store into an existing 32-bit register.
   function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   // Word-address decode; the low two address bits do not take part.
   assign unused_addr_lo = ^bus.addr[1:0];
   assign sel_ack  = (bus.addr[31:2] == ACK_W);
   assign sel_ctrl = (bus.addr[31:2] == CTRL_W);
   assign sel_cnt  = (bus.addr[31:2] == CNT_W);
   assign bus.hit  = sel_ack | sel_ctrl | sel_cnt;
   assign wr       = (|bus.byteen) & bus.hit;

   assign enable  = ctrl[0];
   assign mode    = ctrl[1];
   assign pending = (state == PENDING);
   assign trigger = mode ? (interrupt & ~int_q) : interrupt;

   // Read mux.
   always_comb begin
      bus.rdata = '0;
      if (sel_ack)       bus.rdata = {31'b0, pending};
      else if (sel_ctrl) bus.rdata = {30'b0, ctrl};
      else if (sel_cnt)  bus.rdata = count;
   end

   // Next-state, register writes and irq.
   always_comb begin
      state_nxt  = state;
      ctrl_nxt   = ctrl;
      count_base = count;
      accept     = 1'b0;

      if (wr && sel_ctrl && bus.byteen[0]) ctrl_nxt = bus.wdata[1:0];
      if (wr && sel_cnt) count_base = merge_be(count, bus.wdata, bus.byteen);

      case (state)
         IDLE: begin
            if (trigger && enable) begin
               accept    = 1'b1;
               state_nxt = PENDING;
            end
         end
         PENDING: begin
            if (wr && sel_ack) begin
               // Level line still high must drop before it can retrigger;
               // in edge mode a coincident new edge is accepted right away.
               if (!mode && interrupt) begin
                  state_nxt = ACKED;
               end else if (trigger && enable) begin
                  accept    = 1'b1;
                  state_nxt = PENDING;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         ACKED: begin
            if (!interrupt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      count_nxt = count_base + DW'(accept);
      irq_nxt   = (state_nxt == PENDING) & ctrl_nxt[0];
   end

   // State and register storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ctrl  <= CTRL_RST;
         count <= '0;
         int_q <= 1'b0;
         irq   <= 1'b0;
      end else begin
         state <= state_nxt;
         ctrl  <= ctrl_nxt;
         count <= count_nxt;
         int_q <= interrupt;
         irq   <= irq_nxt;
      end
   end

endmodule

// File: tb/tb_int_ack_ctrl.sv
// Directed, table-driven bench for int_ack_ctrl plus a few hand sequences.
module tb_int_ack_ctrl;

   localparam logic [31:0] A_ACK  = 32'h00007F20;
   localparam logic [31:0] A_CTRL = 32'h00007F24;
   localparam logic [31:0] A_CNT  = 32'h00007F28;
   localparam logic [31:0] A_MISS = 32'h00007F2C;

   typedef struct {
      logic        rst;
      logic        intr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_irq;
      logic [31:0] exp_rdata;
      logic        exp_hit;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic interrupt = 1'b0;
   logic irq;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   int_ack_ctrl_if bus ();

   int_ack_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .interrupt (interrupt),
      .bus       (bus.slave),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic intr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic e_irq, input logic [31:0] e_rd, input logic e_hit);
      vec_t v;
      v.rst = rst; v.intr = intr; v.addr = addr; v.wdata = wdata; v.be = be;
      v.exp_irq = e_irq; v.exp_rdata = e_rd; v.exp_hit = e_hit;
      vecs.push_back(v);
   endtask

   // One bus cycle: drive at negedge, sample 1 time unit after the posedge.
   task automatic cyc(input logic rst, input logic intr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
      @(negedge clk);
      reset = rst; interrupt = intr;
      bus.addr = addr; bus.wdata = wdata; bus.byteen = be;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bus.addr = A_ACK; bus.wdata = '0; bus.byteen = '0;

      //   rst int addr    wdata         be       irq rdata          hit
      add(1, 0, A_ACK,  32'h0,        4'h0,    0, 32'h0,          1); // reset state
      add(1, 0, A_CTRL, 32'h0,        4'h0,    0, 32'h1,          1); // CTRL reset = 1
      add(0, 0, A_CNT,  32'h0,        4'h0,    0, 32'h0,          1);
      add(0, 1, A_ACK,  32'h0,        4'h0,    1, 32'h1,          1); // level accept
      add(0, 1, A_CNT,  32'h0,        4'h0,    1, 32'h1,          1); // COUNT=1
      add(0, 1, A_ACK,  32'h0,        4'hF,    0, 32'h0,          1); // ACK, line high -> ACKED
      for (int i = 0; i < 5; i++)
         add(0, 1, A_ACK, 32'h0,      4'h0,    0, 32'h0,          1); // no retrigger while high
      add(0, 0, A_ACK,  32'h0,        4'h0,    0, 32'h0,          1); // ACKED -> IDLE
      add(0, 1, A_CNT,  32'h0,        4'h0,    1, 32'h2,          1); // re-accept, COUNT=2
      add(0, 0, A_ACK,  32'h0,        4'hF,    0, 32'h0,          1); // ACK, line low -> IDLE
      add(0, 0, A_CTRL, 32'h3,        4'h1,    0, 32'h3,          1); // edge mode
      add(0, 1, A_ACK,  32'h0,        4'h0,    1, 32'h1,          1); // rising edge, COUNT=3
      add(0, 0, A_ACK,  32'h0,        4'h0,    1, 32'h1,          1);
      add(0, 1, A_ACK,  32'h0,        4'hF,    1, 32'h1,          1); // ACK + new edge together
      add(0, 0, A_CNT,  32'h0,        4'h0,    1, 32'h4,          1); // COUNT=4
      add(0, 0, A_CTRL, 32'h0,        4'h1,    0, 32'h0,          1); // disable -> irq drops
      add(0, 0, A_ACK,  32'h0,        4'h0,    0, 32'h1,          1); // pending retained
      add(0, 0, A_CTRL, 32'h1,        4'h1,    1, 32'h1,          1); // re-enable, level
      add(0, 0, A_ACK,  32'h0,        4'hF,    0, 32'h0,          1);
      add(0, 0, A_CNT,  32'hFFFFFFFF, 4'hF,    0, 32'hFFFFFFFF,   1);
      add(0, 1, A_CNT,  32'h0,        4'h0,    1, 32'h0,          1); // COUNT wraps
      add(0, 1, A_CNT,  32'h000000AB, 4'h1,    1, 32'h000000AB,   1); // partial write
      add(0, 1, A_ACK,  32'h0,        4'h0,    1, 32'h1,          1);
      add(1, 0, A_ACK,  32'h0,        4'h0,    0, 32'h0,          1); // reset mid-PENDING
      add(0, 0, A_CTRL, 32'h0,        4'h0,    0, 32'h1,          1);
      add(0, 0, A_CNT,  32'h0,        4'h0,    0, 32'h0,          1);
      add(0, 0, A_MISS, 32'h0,        4'h0,    0, 32'h0,          0); // miss
      add(0, 0, A_MISS, 32'h55,       4'hF,    0, 32'h0,          0); // write on miss ignored
      add(0, 0, A_CNT,  32'h0,        4'h0,    0, 32'h0,          1);
      add(0, 0, 32'h00007F25, 32'h0,  4'h0,    0, 32'h1,          1); // low bits ignored
      add(0, 1, A_CNT,  32'h10,       4'hF,    1, 32'h11,         1); // write + accept
      add(1, 1, A_ACK,  32'h0,        4'h0,    0, 32'h0,          1); // reset, line high
      add(0, 1, A_ACK,  32'h0,        4'h0,    1, 32'h1,          1); // level re-accept
      add(0, 1, A_CNT,  32'h0,        4'h0,    1, 32'h1,          1);
      add(0, 1, A_CTRL, 32'h0,        4'h2,    1, 32'h1,          1); // byte1 only: CTRL kept
      add(0, 1, A_CTRL, 32'h3,        4'h1,    1, 32'h3,          1); // mode change, pending kept
      add(0, 1, A_ACK,  32'h0,        4'hF,    0, 32'h0,          1); // edge ACK -> IDLE
      add(0, 1, A_ACK,  32'h0,        4'h0,    0, 32'h0,          1); // no edge, no trigger
      add(0, 0, A_ACK,  32'h0,        4'h0,    0, 32'h0,          1);
      add(0, 1, A_ACK,  32'h0,        4'h0,    1, 32'h1,          1); // new edge

      foreach (vecs[i]) begin
         cyc(vecs[i].rst, vecs[i].intr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         chk($sformatf("v%0d_irq", i),   32'(irq),       32'(vecs[i].exp_irq));
         chk($sformatf("v%0d_rdata", i), bus.rdata,      vecs[i].exp_rdata);
         chk($sformatf("v%0d_hit", i),   32'(bus.hit),   32'(vecs[i].exp_hit));
      end

      // Latency: line raised at a negedge gives irq right after the next posedge.
      cyc(1, 0, A_ACK, 32'h0, 4'h0);
      cyc(0, 0, A_ACK, 32'h0, 4'h0);
      chk("seq_idle_irq", 32'(irq), 32'h0);
      @(negedge clk);
      interrupt = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!irq && n < 4);
      chk("seq_latency", 32'(n), 32'h1);
      chk("seq_irq_up", 32'(irq), 32'h1);

      // Reset while ACKED, line held high: level re-accept after reset.
      cyc(0, 1, A_ACK, 32'h0, 4'hF);
      chk("seq_acked_irq", 32'(irq), 32'h0);
      cyc(0, 1, A_ACK, 32'h0, 4'h0);
      chk("seq_acked_hold", bus.rdata, 32'h0);
      cyc(1, 1, A_ACK, 32'h0, 4'h0);
      chk("seq_rst_irq", 32'(irq), 32'h0);
      cyc(0, 1, A_CNT, 32'h0, 4'h0);
      chk("seq_reaccept_irq", 32'(irq), 32'h1);
      chk("seq_reaccept_cnt", bus.rdata, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
